// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_e;

  localparam int          MDU_CYCLES_DEF = 32;
  localparam logic [4:0]  REG_ZERO       = 5'd0;

endpackage

// File: rtl/md_busy_timer.sv
// Mul/div busy timer: tracks MDU occupancy and pulses done on the first idle cycle.
module md_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = MDU_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic clrn,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // The counter runs regardless of memory wait states; the MDU is independent.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (start) begin
          state_d = ST_MD_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_MD_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign busy = (state_q == ST_MD_BUSY);
  assign done = done_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: enables, bubbles, flushes, MDU interlock.
// Optional macro STALL_PERF_EN builds the stall_cycles performance counter.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = MDU_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rn,
  input  logic        id_md_start,
  input  logic        id_md_use,
  input  logic        br_taken,
  input  logic        mem_wait,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        id_bubble,
  output logic        ifid_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles
);

  logic load_use;
  logic md_hazard;
  logic id_stall;
  logic md_start;

  assign load_use = ex_wreg & ex_m2reg & (ex_rn != REG_ZERO) &
                    ((id_use_rs & (ex_rn == id_rs)) | (id_use_rt & (ex_rn == id_rt)));
  assign md_hazard = md_busy & (id_md_use | id_md_start);
  assign id_stall  = load_use | md_hazard;
  assign md_start  = ~md_busy & id_md_start & ~mem_wait & ~load_use;

  md_busy_timer #(
    .MDU_CYCLES (MDU_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_timer (
    .clk   (clk),
    .clrn  (clrn),
    .start (md_start),
    .busy  (md_busy),
    .done  (md_done)
  );

  // A memory wait freezes the whole pipe; an ID stall freezes only PC and IF/ID.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    id_bubble  = 1'b0;
    ifid_flush = 1'b0;
    if (mem_wait) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (id_stall) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      id_bubble = 1'b1;
    end else begin
      ifid_flush = br_taken;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_q <= 32'd0;
    end else if (!pc_en) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with MDU_CYCLES=4.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  id_rs, id_rt, ex_rn;
  logic        id_use_rs, id_use_rt, ex_wreg, ex_m2reg;
  logic        id_md_start, id_md_use, br_taken, mem_wait;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        id_bubble, ifid_flush, md_busy, md_done;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, id_bubble, ifid_flush}
  logic [6:0] ctl;
  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, id_bubble, ifid_flush};

  localparam logic [6:0] C_RUN   = 7'b11111_0_0;
  localparam logic [6:0] C_FLUSH = 7'b11111_0_1;
  localparam logic [6:0] C_STALL = 7'b00111_1_0;
  localparam logic [6:0] C_FROZE = 7'b00000_0_0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MDU_CYCLES(4), .CNT_W(6)) dut (
    .clk(clk), .clrn(clrn),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
    .id_md_start(id_md_start), .id_md_use(id_md_use),
    .br_taken(br_taken), .mem_wait(mem_wait),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .id_bubble(id_bubble), .ifid_flush(ifid_flush),
    .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
  );

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rn = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_wreg = 1'b0; ex_m2reg = 1'b0;
    id_md_start = 1'b0; id_md_use = 1'b0; br_taken = 1'b0; mem_wait = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [4:0] rn);
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = rn;
  endtask

  task automatic test_reset();
    idle_inputs();
    clrn = 1'b0;
    #23;
    total++;
    if (ctl !== C_RUN) begin
      bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RUN);
    end
    total++;
    if ({md_busy, md_done} !== 2'b00) begin
      bad++; $display("FAIL reset_md got=%b exp=00", {md_busy, md_done});
    end
    total++;
    if (stall_cycles !== 32'd0) begin
      bad++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles);
    end
    clrn = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    set_load(5'd8); id_rs = 5'd8; id_use_rs = 1'b1;
    #1;
    total++;
    if (ctl !== C_STALL) begin
      bad++; $display("FAIL load_use_rs got=%b exp=%b", ctl, C_STALL);
    end
    step();
    idle_inputs(); id_rs = 5'd8; id_use_rs = 1'b1;
    #1;
    total++;
    if (ctl !== C_RUN) begin
      bad++; $display("FAIL load_use_release got=%b exp=%b", ctl, C_RUN);
    end
    idle_inputs(); set_load(5'd13); id_rt = 5'd13; id_use_rt = 1'b1;
    #1;
    total++;
    if (ctl !== C_STALL) begin
      bad++; $display("FAIL load_use_rt got=%b exp=%b", ctl, C_STALL);
    end
    id_use_rt = 1'b0;
    #1;
    total++;
    if (ctl !== C_RUN) begin
      bad++; $display("FAIL load_use_not_read got=%b exp=%b", ctl, C_RUN);
    end
    ex_m2reg = 1'b0; id_use_rt = 1'b1;
    #1;
    total++;
    if (ctl !== C_RUN) begin
      bad++; $display("FAIL load_use_not_load got=%b exp=%b", ctl, C_RUN);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reg0();
    set_load(5'd0); id_rs = 5'd0; id_use_rs = 1'b1; id_rt = 5'd0; id_use_rt = 1'b1;
    #1;
    total++;
    if (ctl !== C_RUN) begin
      bad++; $display("FAIL reg0_no_stall got=%b exp=%b", ctl, C_RUN);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_branch();
    br_taken = 1'b1;
    #1;
    total++;
    if (ctl !== C_FLUSH) begin
      bad++; $display("FAIL branch_flush got=%b exp=%b", ctl, C_FLUSH);
    end
    step();
    br_taken = 1'b0;
    #1;
    total++;
    if (ctl !== C_RUN) begin
      bad++; $display("FAIL branch_after got=%b exp=%b", ctl, C_RUN);
    end
    br_taken = 1'b1; set_load(5'd5); id_rs = 5'd5; id_use_rs = 1'b1;
    #1;
    total++;
    if (ctl !== C_STALL) begin
      bad++; $display("FAIL branch_with_load_use got=%b exp=%b", ctl, C_STALL);
    end
    mem_wait = 1'b1;
    #1;
    total++;
    if (ctl !== C_FROZE) begin
      bad++; $display("FAIL branch_with_mem_wait got=%b exp=%b", ctl, C_FROZE);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_mdu();
    id_md_start = 1'b1;
    #1;
    total++;
    if (ctl !== C_RUN || md_busy !== 1'b0) begin
      bad++; $display("FAIL mdu_issue got=%b/%b exp=%b/0", ctl, md_busy, C_RUN);
    end
    step();
    id_md_start = 1'b0; id_md_use = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) begin
        set_load(5'd3); id_rs = 5'd3; id_use_rs = 1'b1;
      end else begin
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rn = 5'd0; id_use_rs = 1'b0;
      end
      #1;
      total++;
      if (ctl !== C_STALL || md_busy !== 1'b1 || md_done !== 1'b0) begin
        bad++;
        $display("FAIL mdu_busy_cycle%0d got=%b/%b/%b exp=%b/1/0", i, ctl, md_busy, md_done, C_STALL);
      end
      step();
    end
    #1;
    total++;
    if (ctl !== C_RUN || md_busy !== 1'b0 || md_done !== 1'b1) begin
      bad++; $display("FAIL mdu_done_release got=%b/%b/%b exp=%b/0/1", ctl, md_busy, md_done, C_RUN);
    end
    step();
    id_md_use = 1'b0;
    total++;
    if (md_done !== 1'b0) begin
      bad++; $display("FAIL mdu_done_pulse_width got=%b exp=0", md_done);
    end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    id_md_start = 1'b1;
    step();
    id_md_start = 1'b0; id_md_use = 1'b1; mem_wait = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      total++;
      if (ctl !== C_FROZE || md_busy !== 1'b1) begin
        bad++; $display("FAIL mem_wait_cycle%0d got=%b/%b exp=%b/1", i, ctl, md_busy, C_FROZE);
      end
      step();
    end
    mem_wait = 1'b0;
    #1;
    total++;
    if (ctl !== C_STALL || md_busy !== 1'b1) begin
      bad++; $display("FAIL mem_wait_then_hazard got=%b/%b exp=%b/1", ctl, md_busy, C_STALL);
    end
    step();
    total++;
    if (md_done !== 1'b1 || md_busy !== 1'b0 || ctl !== C_RUN) begin
      bad++; $display("FAIL mem_wait_done_timing got=%b/%b/%b exp=1/0/%b", md_done, md_busy, ctl, C_RUN);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    int done_seen;
    id_md_start = 1'b1;
    step();
    id_md_start = 1'b0;
    step();
    #2;
    clrn = 1'b0;
    #1;
    total++;
    if (md_busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_busy got=%b exp=0", md_busy);
    end
    step();
    clrn = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (md_done !== 1'b0 || md_busy !== 1'b0) done_seen++;
    end
    total++;
    if (done_seen != 0) begin
      bad++; $display("FAIL reset_mid_no_done got=%0d exp=0", done_seen);
    end
    total++;
    if (stall_cycles !== 32'd0) begin
      bad++; $display("FAIL reset_mid_stall_cycles got=%0d exp=0", stall_cycles);
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp_cnt;
    set_load(5'd9); id_rt = 5'd9; id_use_rt = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    idle_inputs();
`ifdef STALL_PERF_EN
    exp_cnt = 32'd5;
`else
    exp_cnt = 32'd0;
`endif
    total++;
    if (stall_cycles !== exp_cnt) begin
      bad++; $display("FAIL perf_count got=%0d exp=%0d", stall_cycles, exp_cnt);
    end
    step();
    total++;
    if (stall_cycles !== exp_cnt) begin
      bad++; $display("FAIL perf_hold got=%0d exp=%0d", stall_cycles, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg0();
    test_branch();
    test_mdu();
    test_mem_wait();
    test_reset_mid();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
